dm_cache_controller: RTL and testbench

Control FSM for the direct-mapped cache. It sits between the CPU request interface and the tag/data array datapath, and directly upstream of axi4_controller. It decides hit or miss, then sequences dirty write-back (start_write) and line refill (start_read), waiting on axi_ack for each. It also runs a full-cache flush that writes back every valid dirty line.

---
 rtl/cache_pkg.sv | 19 +
 rtl/dm_cache_controller.sv | 159 +++++++++++++++
 tb/tb_dm_cache_controller.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped cache control path.
// Imported by the controller and by anything that decodes its state or request type.
package cache_pkg;

    localparam int NUM_LINES_DEF = 16;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        COMPARE     = 3'd1,
        WRITEBACK   = 3'd2,
        ALLOCATE    = 3'd3,
        FLUSH_CHECK = 3'd4,
        FLUSH_WB    = 3'd5
    } state_t;

endpackage

// File: rtl/dm_cache_controller.sv
// Control FSM of the direct-mapped cache: hit/miss decision, dirty write-back,
// line refill and full-cache flush, handshaking with axi4_controller via start_*/axi_ack.
module dm_cache_controller
    import cache_pkg::*;
#(
    parameter  int NUM_LINES = NUM_LINES_DEF,
    localparam int INDEX_W   = $clog2(NUM_LINES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_req_valid,
    input  logic               cpu_req_rw,
    input  logic               cpu_flush,
    input  logic               cache_hit,
    input  logic               line_valid,
    input  logic               line_dirty,
    input  logic               axi_ack,
    output logic               cpu_ready,
    output logic               req_latch,
    output logic               cpu_done,
    output logic               word_wr_en,
    output logic               line_wr_en,
    output logic               set_valid,
    output logic               set_dirty,
    output logic               clr_dirty,
    output logic               wb_sel,
    output logic               flush_sel,
    output logic [INDEX_W-1:0] flush_index,
    output logic               flush_done,
    output logic               start_write,
    output logic               start_read
);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_rw;
    logic [INDEX_W-1:0] r_flush_index;
    logic [INDEX_W-1:0] w_flush_index_nxt;
    logic               w_flush_last;

    assign flush_index  = r_flush_index;
    assign w_flush_last = (r_flush_index == INDEX_W'(NUM_LINES - 1));

    // State, latched request type and flush line counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_rw          <= RW_READ;
            r_flush_index <= '0;
        end else begin
            r_state       <= w_next_state;
            r_rw          <= req_latch ? cpu_req_rw : r_rw;
            r_flush_index <= w_flush_index_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_next_state      = r_state;
        w_flush_index_nxt = r_flush_index;
        cpu_ready         = 1'b0;
        req_latch         = 1'b0;
        cpu_done          = 1'b0;
        word_wr_en        = 1'b0;
        line_wr_en        = 1'b0;
        set_valid         = 1'b0;
        set_dirty         = 1'b0;
        clr_dirty         = 1'b0;
        wb_sel            = 1'b0;
        flush_sel         = 1'b0;
        flush_done        = 1'b0;
        start_write       = 1'b0;
        start_read        = 1'b0;
        case (r_state)
            IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_flush) begin
                    w_flush_index_nxt = '0;
                    w_next_state      = FLUSH_CHECK;
                end else if (cpu_req_valid) begin
                    req_latch    = 1'b1;
                    w_next_state = COMPARE;
                end else begin
                    w_next_state = IDLE;
                end
            end
            COMPARE: begin
                if (cache_hit) begin
                    cpu_done     = 1'b1;
                    word_wr_en   = (r_rw == RW_WRITE);
                    set_dirty    = (r_rw == RW_WRITE);
                    w_next_state = IDLE;
                end else if (line_valid && line_dirty) begin
                    w_next_state = WRITEBACK;
                end else begin
                    w_next_state = ALLOCATE;
                end
            end
            WRITEBACK: begin
                start_write = 1'b1;
                wb_sel      = 1'b1;
                if (axi_ack) begin
                    clr_dirty    = 1'b1;
                    w_next_state = ALLOCATE;
                end else begin
                    w_next_state = WRITEBACK;
                end
            end
            ALLOCATE: begin
                // Refill completes the line; the following COMPARE always hits
                start_read = 1'b1;
                if (axi_ack) begin
                    line_wr_en   = 1'b1;
                    set_valid    = 1'b1;
                    clr_dirty    = 1'b1;
                    w_next_state = COMPARE;
                end else begin
                    w_next_state = ALLOCATE;
                end
            end
            FLUSH_CHECK: begin
                flush_sel = 1'b1;
                if (line_valid && line_dirty) begin
                    w_next_state = FLUSH_WB;
                end else if (w_flush_last) begin
                    flush_done        = 1'b1;
                    w_flush_index_nxt = '0;
                    w_next_state      = IDLE;
                end else begin
                    w_flush_index_nxt = r_flush_index + INDEX_W'(1);
                    w_next_state      = FLUSH_CHECK;
                end
            end
            FLUSH_WB: begin
                flush_sel   = 1'b1;
                wb_sel      = 1'b1;
                start_write = 1'b1;
                if (axi_ack) begin
                    clr_dirty = 1'b1;
                    if (w_flush_last) begin
                        flush_done        = 1'b1;
                        w_flush_index_nxt = '0;
                        w_next_state      = IDLE;
                    end else begin
                        w_flush_index_nxt = r_flush_index + INDEX_W'(1);
                        w_next_state      = FLUSH_CHECK;
                    end
                end else begin
                    w_next_state = FLUSH_WB;
                end
            end
            default: begin
                w_next_state      = IDLE;
                w_flush_index_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_dm_cache_controller.sv
// Self-checking bench: behavioural tag/valid/dirty arrays act as the datapath,
// an AXI responder acks after a programmable delay, and a line-level model predicts outcomes.
module tb_dm_cache_controller;
    import cache_pkg::*;

    localparam int NL = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req_valid, cpu_req_rw, cpu_flush;
    logic          cache_hit, line_valid, line_dirty, axi_ack;
    logic          cpu_ready, req_latch, cpu_done, word_wr_en, line_wr_en;
    logic          set_valid, set_dirty, clr_dirty, wb_sel, flush_sel;
    logic [IW-1:0] flush_index;
    logic          flush_done, start_write, start_read;

    dm_cache_controller #(.NUM_LINES(NL)) dut (
        .clk(clk), .reset(rst_n), .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw),
        .cpu_flush(cpu_flush), .cache_hit(cache_hit), .line_valid(line_valid),
        .line_dirty(line_dirty), .axi_ack(axi_ack), .cpu_ready(cpu_ready),
        .req_latch(req_latch), .cpu_done(cpu_done), .word_wr_en(word_wr_en),
        .line_wr_en(line_wr_en), .set_valid(set_valid), .set_dirty(set_dirty),
        .clr_dirty(clr_dirty), .wb_sel(wb_sel), .flush_sel(flush_sel),
        .flush_index(flush_index), .flush_done(flush_done),
        .start_write(start_write), .start_read(start_read)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural datapath arrays
    logic          dp_valid [NL];
    logic          dp_dirty [NL];
    logic [3:0]    dp_tag   [NL];
    logic          dp_clear;
    logic [IW-1:0] cpu_idx, lat_idx;
    logic [3:0]    cpu_tag, lat_tag;
    logic [IW-1:0] sel;

    // Reference model of cache line state
    bit            m_valid [NL];
    bit            m_dirty [NL];
    logic [3:0]    m_tag   [NL];

    assign sel        = flush_sel ? flush_index : lat_idx;
    assign cache_hit  = dp_valid[sel] && (dp_tag[sel] == lat_tag);
    assign line_valid = dp_valid[sel];
    assign line_dirty = dp_dirty[sel];

    always @(posedge clk) begin
        if (dp_clear) begin
            for (int i = 0; i < NL; i++) begin
                dp_valid[i] <= 1'b0;
                dp_dirty[i] <= 1'b0;
                dp_tag[i]   <= 4'd0;
            end
            lat_idx <= '0;
            lat_tag <= 4'd0;
        end else begin
            if (req_latch) begin
                lat_idx <= cpu_idx;
                lat_tag <= cpu_tag;
            end
            if (line_wr_en) dp_tag[sel] <= lat_tag;
            if (set_valid)  dp_valid[sel] <= 1'b1;
            if (clr_dirty)  dp_dirty[sel] <= 1'b0;
            if (set_dirty)  dp_dirty[sel] <= 1'b1;
        end
    end

    // AXI responder: ack lands in the ack_lat-th cycle of a start_* level
    logic ack_r, spur;
    int   ack_cnt;
    int   ack_lat = 3;
    assign axi_ack = ack_r | spur;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r   <= 1'b0;
            ack_cnt <= 0;
        end else if (ack_r) begin
            ack_r   <= 1'b0;
            ack_cnt <= 0;
        end else if (start_read || start_write) begin
            ack_cnt <= ack_cnt + 1;
            ack_r   <= (ack_cnt + 2 == ack_lat);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int other_outs();
        return int'({req_latch, cpu_done, word_wr_en, line_wr_en, set_valid, set_dirty,
                     clr_dirty, wb_sel, flush_sel, flush_done, start_write, start_read});
    endfunction

    task automatic chk_line(input int i);
        chk("line_valid_state", int'(dp_valid[i]), int'(m_valid[i]));
        chk("line_dirty_state", int'(dp_dirty[i]), int'(m_dirty[i]));
        if (m_valid[i]) chk("line_tag_state", int'(dp_tag[i]), int'(m_tag[i]));
    endtask

    task automatic do_req(input logic [3:0] idx, input logic [3:0] tag, input logic rw,
                          input int lat, input int e_done, input int e_nwr, input int e_nrd);
        int cyc, nwr, nrd, done_cyc, ovl, ww, sd;
        bit hit;
        hit = m_valid[idx] && (m_tag[idx] == tag);
        ack_lat = lat;
        @(negedge clk);
        chk("ready_before_req", int'(cpu_ready), 1);
        cpu_idx = idx; cpu_tag = tag; cpu_req_rw = rw; cpu_req_valid = 1'b1;
        #1 chk("req_latch", int'(req_latch), 1);
        @(negedge clk);
        cpu_req_valid = 1'b0; cpu_req_rw = ~rw; cpu_idx = ~idx;
        cyc = 1; done_cyc = -1; nwr = 0; nrd = 0; ovl = 0; ww = -1; sd = -1;
        while (cyc < 100) begin
            #1;
            if (start_read && start_write) ovl++;
            nwr += int'(start_write);
            nrd += int'(start_read);
            if (cpu_done) begin
                done_cyc = cyc; ww = int'(word_wr_en); sd = int'(set_dirty);
                break;
            end
            @(negedge clk);
            cyc++;
        end
        chk("done_cycle", done_cyc, e_done);
        chk("start_write_cycles", nwr, e_nwr);
        chk("start_read_cycles", nrd, e_nrd);
        chk("start_overlap", ovl, 0);
        chk("word_wr_en_at_done", ww, int'(rw));
        chk("set_dirty_at_done", sd, int'(rw));
        @(negedge clk);
        #1 chk("done_pulse_one_cycle", int'(cpu_done), 0);
        chk("ready_after_req", int'(cpu_ready), 1);
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
        m_dirty[idx] = rw ? 1'b1 : (hit ? m_dirty[idx] : 1'b0);
        chk_line(idx);
    endtask

    task automatic do_model_req(input logic [3:0] idx, input logic [3:0] tag, input logic rw,
                                input int lat);
        bit hit, dm;
        hit = m_valid[idx] && (m_tag[idx] == tag);
        dm  = !hit && m_valid[idx] && m_dirty[idx];
        do_req(idx, tag, rw, lat, hit ? 1 : 2 + (dm ? lat : 0) + lat, dm ? lat : 0, hit ? 0 : lat);
    endtask

    task automatic do_flush(input int lat);
        int exp_q[$];
        int got_q[$];
        int cyc, bad, dirty_left;
        bit prev_sw, done;
        for (int i = 0; i < NL; i++) if (m_valid[i] && m_dirty[i]) exp_q.push_back(i);
        ack_lat = lat;
        @(negedge clk);
        cpu_flush = 1'b1; cpu_req_valid = 1'b1;
        #1 chk("flush_priority_no_latch", int'(req_latch), 0);
        @(negedge clk);
        cpu_flush = 1'b0;
        cyc = 1; bad = 0; prev_sw = 1'b0; done = 1'b0;
        while (cyc < 400) begin
            #1;
            if (req_latch) bad++;
            if (start_write && !prev_sw) got_q.push_back(int'(flush_index));
            prev_sw = start_write;
            if (flush_done) begin
                cpu_req_valid = 1'b0;
                done = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        cpu_req_valid = 1'b0;
        chk("flush_done_seen", int'(done), 1);
        chk("flush_req_ignored", bad, 0);
        chk("flush_wb_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("flush_wb_index", got_q[i], exp_q[i]);
        @(negedge clk);
        #1 chk("ready_after_flush", int'(cpu_ready), 1);
        chk("flush_index_after_flush", int'(flush_index), 0);
        chk("flush_done_one_cycle", int'(flush_done), 0);
        dirty_left = 0;
        for (int i = 0; i < NL; i++) begin
            m_dirty[i] = 1'b0;
            if (dp_dirty[i] || (dp_valid[i] != m_valid[i])) dirty_left++;
        end
        chk("lines_after_flush", dirty_left, 0);
    endtask

    typedef struct {
        logic [3:0] idx;
        logic [3:0] tag;
        logic       rw;
        int         done;
        int         nwr;
        int         nrd;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int cyc;
        tbl[0] = '{4'd2,  4'd5, RW_READ,  5, 0, 3};
        tbl[1] = '{4'd2,  4'd5, RW_READ,  1, 0, 0};
        tbl[2] = '{4'd2,  4'd5, RW_WRITE, 1, 0, 0};
        tbl[3] = '{4'd2,  4'd9, RW_READ,  8, 3, 3};
        tbl[4] = '{4'd2,  4'd9, RW_READ,  1, 0, 0};
        tbl[5] = '{4'd7,  4'd1, RW_WRITE, 5, 0, 3};
        tbl[6] = '{4'd15, 4'd3, RW_WRITE, 5, 0, 3};
        tbl[7] = '{4'd0,  4'd4, RW_WRITE, 5, 0, 3};

        rst_n = 1'b0; dp_clear = 1'b1; spur = 1'b0;
        cpu_req_valid = 1'b0; cpu_req_rw = 1'b0; cpu_flush = 1'b0;
        cpu_idx = '0; cpu_tag = 4'd0;
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = 4'd0;
        end
        @(negedge clk);
        @(negedge clk);
        #1 chk("reset_cpu_ready", int'(cpu_ready), 1);
        chk("reset_outputs_zero", other_outs(), 0);
        chk("reset_flush_index", int'(flush_index), 0);
        dp_clear = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++)
            do_req(tbl[v].idx, tbl[v].tag, tbl[v].rw, 3, tbl[v].done, tbl[v].nwr, tbl[v].nrd);

        // Dirty lines are now 0, 7 and 15
        do_flush(3);

        // Reset in the middle of an otherwise clean flush walk
        @(negedge clk);
        cpu_flush = 1'b1;
        @(negedge clk);
        cpu_flush = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk("flush_index_mid_walk", int'(flush_index), 3);
        rst_n = 1'b0;
        #1 chk("flush_index_async_reset", int'(flush_index), 0);
        chk("ready_async_reset_flush", int'(cpu_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 40; n++)
            do_model_req(4'($urandom_range(0, NL - 1)), 4'($urandom_range(0, 7)),
                         1'($urandom_range(0, 1)), $urandom_range(2, 5));
        do_flush($urandom_range(2, 5));
        for (int n = 0; n < 20; n++)
            do_model_req(4'($urandom_range(0, NL - 1)), 4'($urandom_range(0, 7)),
                         1'($urandom_range(0, 1)), $urandom_range(2, 5));

        // Reset while ALLOCATE waits for its ack
        ack_lat = 6;
        @(negedge clk);
        cpu_idx = 4'd5; cpu_tag = 4'd15; cpu_req_rw = RW_READ; cpu_req_valid = 1'b1;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cyc = 0;
        while (cyc < 50) begin
            #1;
            if (start_read) break;
            @(negedge clk);
            cyc++;
        end
        chk("alloc_reached", int'(start_read), 1);
        rst_n = 1'b0;
        #1 chk("alloc_reset_start_read", int'(start_read), 0);
        chk("alloc_reset_ready", int'(cpu_ready), 1);
        chk("alloc_reset_flush_index", int'(flush_index), 0);
        chk("alloc_reset_outputs", other_outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        spur = 1'b1;
        #1 chk("spurious_ack_outputs", other_outs(), 0);
        chk("spurious_ack_ready", int'(cpu_ready), 1);
        @(negedge clk);
        spur = 1'b0;
        #1 chk("after_spurious_outputs", other_outs(), 0);
        chk("after_spurious_ready", int'(cpu_ready), 1);
        chk_line(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
